// File: rtl/tag_ram_sync_nway_pkg.sv
// tag_ram_pkg: shared op encodings, FSM state type and way-index width helper
// for the N-way tag RAM.
package tag_ram_pkg;
   localparam logic [1:0] OP_LOOKUP  = 2'b00;
   localparam logic [1:0] OP_FILL    = 2'b01;
   localparam logic [1:0] OP_INV_WAY = 2'b10;
   localparam logic [1:0] OP_INV_IDX = 2'b11;
   typedef enum logic {INIT, READY} state_t;
   function automatic int wwidth(input int ways);
      return (ways > 1) ? $clog2(ways) : 1;
   endfunction
endpackage

// File: rtl/tag_ram_sync_nway_if.sv
// tag_ram_sync_nway_if: request/response/init bundle between the cache
// controller (master) and the tag RAM (slave).
interface tag_ram_sync_nway_if import tag_ram_pkg::*; #(
   parameter int AWIDTH = 3,
   parameter int TWIDTH = 14,
   parameter int WAYS   = 2
);
   localparam int WWIDTH = wwidth(WAYS);
   logic                   req_valid;
   logic                   req_ready;
   logic [1:0]             req_op;
   logic [AWIDTH-1:0]      req_addr;
   logic [WWIDTH-1:0]      req_way;
   logic [TWIDTH-1:0]      req_tag;
   logic                   rsp_valid;
   logic                   rsp_hit;
   logic [WWIDTH-1:0]      rsp_way;
   logic [WAYS*TWIDTH-1:0] rsp_tags;
   logic [WAYS-1:0]        rsp_vbits;
   logic                   init_start;
   logic                   init_busy;
   modport master (
      output req_valid, req_op, req_addr, req_way, req_tag, init_start,
      input  req_ready, rsp_valid, rsp_hit, rsp_way, rsp_tags, rsp_vbits, init_busy
   );
   modport slave (
      input  req_valid, req_op, req_addr, req_way, req_tag, init_start,
      output req_ready, rsp_valid, rsp_hit, rsp_way, rsp_tags, rsp_vbits, init_busy
   );
endinterface

// File: rtl/tag_ram_sync_nway_way.sv
// ram_sync_rw_way: one way of {valid, tag} storage with a registered read
// address; valid and tag have separate enables so invalidation keeps the tag.
module ram_sync_rw_way #(
   parameter int AWIDTH = 3,
   parameter int TWIDTH = 14
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              rd_en,
   input  logic [AWIDTH-1:0] rd_addr,
   input  logic [AWIDTH-1:0] wr_addr,
   input  logic              wr_vld_en,
   input  logic              wr_tag_en,
   input  logic              wr_vld,
   input  logic [TWIDTH-1:0] wr_tag,
   output logic              rd_vld,
   output logic [TWIDTH-1:0] rd_tag
);
   localparam int DEPTH = 1 << AWIDTH;
   logic              mem_vld_q [DEPTH];
   logic [TWIDTH-1:0] mem_tag_q [DEPTH];
   logic [AWIDTH-1:0] rd_addr_q, rd_addr_d;
   always_comb rd_addr_d = rd_en ? rd_addr : rd_addr_q;
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) rd_addr_q <= '0;
      else rd_addr_q <= rd_addr_d;
   end
   always_ff @(posedge clock) begin
      if (wr_vld_en) mem_vld_q[wr_addr] <= wr_vld;
      if (wr_tag_en) mem_tag_q[wr_addr] <= wr_tag;
   end
   assign rd_vld = mem_vld_q[rd_addr_q];
   assign rd_tag = mem_tag_q[rd_addr_q];
endmodule

// File: rtl/tag_ram_sync_nway.sv
// tag_ram_sync_nway: N-way tag RAM with clear sweep FSM, write decode and a
// registered hit compare / priority encode one cycle after the read.
module tag_ram_sync_nway import tag_ram_pkg::*; #(
   parameter int AWIDTH = 3,
   parameter int TWIDTH = 14,
   parameter int WAYS   = 2
) (
   input logic                 clock,
   input logic                 reset_n,
   tag_ram_sync_nway_if.slave  bus
);
   localparam int DEPTH  = 1 << AWIDTH;
   localparam int WWIDTH = wwidth(WAYS);
   state_t                 state_q, state_d;
   logic [AWIDTH-1:0]      idx_q, idx_d, wr_addr;
   logic                   lk_q, lk_d, accept, sweep, wr_vld, hit;
   logic [TWIDTH-1:0]      cmp_tag_q, cmp_tag_d, wr_tag;
   logic [WAYS-1:0]        wr_vld_en, wr_tag_en, rd_vld, rsp_vbits_q, rsp_vbits_d;
   logic [TWIDTH-1:0]      rd_tag [WAYS];
   logic [WWIDTH-1:0]      hit_way, rsp_way_q, rsp_way_d;
   logic [WAYS*TWIDTH-1:0] rd_tags, rsp_tags_q, rsp_tags_d;
   logic                   rsp_valid_q, rsp_valid_d, rsp_hit_q, rsp_hit_d;
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= INIT;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
      end
   end
   always_comb begin
      state_d = (state_q == INIT) ? ((idx_q == AWIDTH'(DEPTH - 1)) ? READY : INIT)
                                  : (bus.init_start ? INIT : READY);
      idx_d   = (state_q == INIT) ? idx_q + AWIDTH'(1) : '0;
   end
   // Sweep owns the write port; requests are only accepted outside it.
   always_comb begin
      sweep         = (state_q == INIT);
      bus.req_ready = !sweep;
      bus.init_busy = sweep;
      accept        = bus.req_valid && !sweep;
      wr_addr       = sweep ? idx_q : bus.req_addr;
      wr_vld        = !sweep && (bus.req_op == OP_FILL);
      wr_tag        = sweep ? '0 : bus.req_tag;
      lk_d          = accept && (bus.req_op == OP_LOOKUP);
      cmp_tag_d     = lk_d ? bus.req_tag : cmp_tag_q;
      wr_vld_en     = '0;
      wr_tag_en     = '0;
      for (int w = 0; w < WAYS; w++) begin
         wr_tag_en[w] = sweep || (accept && bus.req_op == OP_FILL && WWIDTH'(w) == bus.req_way);
         wr_vld_en[w] = wr_tag_en[w] || (accept && (bus.req_op == OP_INV_IDX ||
                        (bus.req_op == OP_INV_WAY && WWIDTH'(w) == bus.req_way)));
      end
   end
   for (genvar w = 0; w < WAYS; w++) begin : g_way
      ram_sync_rw_way #(.AWIDTH(AWIDTH), .TWIDTH(TWIDTH)) u_way (
         .clock(clock), .reset_n(reset_n), .rd_en(lk_d), .rd_addr(bus.req_addr),
         .wr_addr(wr_addr), .wr_vld_en(wr_vld_en[w]), .wr_tag_en(wr_tag_en[w]),
         .wr_vld(wr_vld), .wr_tag(wr_tag), .rd_vld(rd_vld[w]), .rd_tag(rd_tag[w])
      );
   end
   always_comb begin
      hit     = 1'b0;
      hit_way = '0;
      rd_tags = '0;
      for (int i = WAYS - 1; i >= 0; i--) begin
         rd_tags[i*TWIDTH +: TWIDTH] = rd_tag[i];
         if (rd_vld[i] && rd_tag[i] == cmp_tag_q) begin
            hit     = 1'b1;
            hit_way = WWIDTH'(i);
         end
      end
      rsp_valid_d = lk_q;
      rsp_hit_d   = lk_q ? hit : rsp_hit_q;
      rsp_way_d   = lk_q ? hit_way : rsp_way_q;
      rsp_tags_d  = lk_q ? rd_tags : rsp_tags_q;
      rsp_vbits_d = lk_q ? rd_vld : rsp_vbits_q;
   end
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         lk_q        <= 1'b0;
         cmp_tag_q   <= '0;
         rsp_valid_q <= 1'b0;
         rsp_hit_q   <= 1'b0;
         rsp_way_q   <= '0;
         rsp_tags_q  <= '0;
         rsp_vbits_q <= '0;
      end else begin
         lk_q        <= lk_d;
         cmp_tag_q   <= cmp_tag_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_hit_q   <= rsp_hit_d;
         rsp_way_q   <= rsp_way_d;
         rsp_tags_q  <= rsp_tags_d;
         rsp_vbits_q <= rsp_vbits_d;
      end
   end
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_hit   = rsp_hit_q;
   assign bus.rsp_way   = rsp_way_q;
   assign bus.rsp_tags  = rsp_tags_q;
   assign bus.rsp_vbits = rsp_vbits_q;
endmodule

// File: tb/tb_tag_ram_sync_nway.sv
// tb_tag_ram_sync_nway: scoreboard bench; a reference model predicts each
// lookup response and its arrival cycle, a monitor pops and compares.
module tb_tag_ram_sync_nway;
   import tag_ram_pkg::*;
   localparam int AW = 3;
   localparam int TW = 14;
   localparam int W  = 2;
   localparam int D  = 1 << AW;
   typedef struct {
      int             due;
      logic           hit;
      logic [0:0]     way;
      logic [W*TW-1:0] tags;
      logic [W-1:0]   vbits;
   } exp_t;
   logic clock, reset_n;
   int total, bad, cyc, n;
   exp_t q[$];
   logic          mv [W][D];
   logic [TW-1:0] mt [W][D];
   tag_ram_sync_nway_if #(.AWIDTH(AW), .TWIDTH(TW), .WAYS(W)) bus ();
   tag_ram_sync_nway #(.AWIDTH(AW), .TWIDTH(TW), .WAYS(W)) dut (
      .clock(clock), .reset_n(reset_n), .bus(bus)
   );
   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask
   task automatic clear_model();
      for (int w = 0; w < W; w++)
         for (int a = 0; a < D; a++) begin
            mv[w][a] = 1'b0;
            mt[w][a] = '0;
         end
   endtask
   task automatic check_reset();
      chk("rst_ready", 32'(bus.req_ready), 0);
      chk("rst_busy", 32'(bus.init_busy), 1);
      chk("rst_valid", 32'(bus.rsp_valid), 0);
      chk("rst_hit", 32'(bus.rsp_hit), 0);
      chk("rst_way", 32'(bus.rsp_way), 0);
      chk("rst_tags", 32'(bus.rsp_tags), 0);
      chk("rst_vbits", 32'(bus.rsp_vbits), 0);
   endtask
   task automatic count_busy(output int cnt);
      cnt = 0;
      while (bus.init_busy && cnt < 100) begin
         chk("ready_low", 32'(bus.req_ready), 0);
         cnt++;
         @(negedge clock);
      end
   endtask
   task automatic do_op(input logic [1:0] op, input int a, input int w,
                        input logic [TW-1:0] t, input logic init = 1'b0);
      exp_t e;
      bus.req_valid  = 1'b1;
      bus.req_op     = op;
      bus.req_addr   = AW'(a);
      bus.req_way    = 1'(w);
      bus.req_tag    = t;
      bus.init_start = init;
      chk("accept", 32'(bus.req_ready), 1);
      if (bus.req_ready) begin
         if (op == OP_LOOKUP) begin
            e.due = cyc + 2;
            e.hit = 1'b0;
            e.way = '0;
            for (int i = 0; i < W; i++) begin
               e.tags[i*TW +: TW] = mt[i][a];
               e.vbits[i] = mv[i][a];
               if (!e.hit && mv[i][a] && mt[i][a] == t) begin
                  e.hit = 1'b1;
                  e.way = 1'(i);
               end
            end
            q.push_back(e);
         end else if (op == OP_FILL) begin
            mv[w][a] = 1'b1;
            mt[w][a] = t;
         end else if (op == OP_INV_WAY) mv[w][a] = 1'b0;
         else for (int i = 0; i < W; i++) mv[i][a] = 1'b0;
      end
      if (init) clear_model();
      @(negedge clock);
      bus.req_valid  = 1'b0;
      bus.init_start = 1'b0;
   endtask
   task automatic idle(input int cnt);
      bus.req_valid = 1'b0;
      repeat (cnt) @(negedge clock);
   endtask
   always @(negedge clock) begin
      exp_t e;
      if (reset_n) begin
         if (q.size() > 0 && q[0].due < cyc) begin
            chk("rsp_missing", 32'(cyc), 32'(q[0].due));
            q.delete(0);
         end
         if (bus.rsp_valid) begin
            if (q.size() == 0) chk("rsp_spurious", 32'(bus.rsp_valid), 0);
            else begin
               e = q.pop_front();
               chk("rsp_cycle", 32'(cyc), 32'(e.due));
               chk("rsp_hit", 32'(bus.rsp_hit), 32'(e.hit));
               chk("rsp_way", 32'(bus.rsp_way), 32'(e.way));
               chk("rsp_tags", 32'(bus.rsp_tags), 32'(e.tags));
               chk("rsp_vbits", 32'(bus.rsp_vbits), 32'(e.vbits));
            end
         end
      end
   end
   initial begin
      #100000;
      $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
      $fatal(1);
   end
   initial begin
      clock = 1'b0;
      reset_n = 1'b0;
      cyc = 0;
      total = 0;
      bad = 0;
      bus.req_valid = 1'b0;
      bus.req_op = OP_LOOKUP;
      bus.req_addr = '0;
      bus.req_way = '0;
      bus.req_tag = '0;
      bus.init_start = 1'b0;
      clear_model();
      repeat (2) @(negedge clock);
      check_reset();
      reset_n = 1'b1;
      count_busy(n);
      chk("busy_len", 32'(n), 8);
      chk("ready_up", 32'(bus.req_ready), 1);
      for (int a = 0; a < D; a++) do_op(OP_LOOKUP, a, 0, 14'h0);
      do_op(OP_FILL, 5, 1, 14'h1A3);
      do_op(OP_LOOKUP, 5, 0, 14'h1A3);
      do_op(OP_LOOKUP, 5, 0, 14'h1A4);
      do_op(OP_FILL, 2, 0, 14'h0F0);
      do_op(OP_FILL, 2, 1, 14'h0F0);
      do_op(OP_LOOKUP, 2, 0, 14'h0F0);
      do_op(OP_INV_WAY, 2, 0, 14'h0);
      do_op(OP_LOOKUP, 2, 0, 14'h0F0);
      do_op(OP_INV_IDX, 2, 0, 14'h0);
      do_op(OP_LOOKUP, 2, 0, 14'h0F0);
      do_op(OP_FILL, 1, 0, 14'h111);
      do_op(OP_FILL, 6, 1, 14'h222);
      do_op(OP_FILL, 7, 0, 14'h333);
      do_op(OP_LOOKUP, 6, 0, 14'h222, 1'b1);
      count_busy(n);
      chk("busy_len_init", 32'(n), 8);
      do_op(OP_LOOKUP, 1, 0, 14'h111);
      do_op(OP_LOOKUP, 6, 0, 14'h222);
      do_op(OP_LOOKUP, 7, 0, 14'h333);
      do_op(OP_LOOKUP, 5, 0, 14'h1A3);
      do_op(OP_FILL, 3, 0, 14'h3C5);
      do_op(OP_LOOKUP, 3, 0, 14'h3C5);
      idle(3);
      bus.init_start = 1'b1;
      @(negedge clock);
      bus.init_start = 1'b0;
      repeat (4) @(negedge clock);
      chk("mid_sweep_busy", 32'(bus.init_busy), 1);
      reset_n = 1'b0;
      #1;
      check_reset();
      q.delete();
      clear_model();
      @(negedge clock);
      check_reset();
      reset_n = 1'b1;
      count_busy(n);
      chk("busy_len_rst", 32'(n), 8);
      for (int k = 0; k < 16; k++)
         do_op(2'($urandom_range(0, 3)), int'($urandom_range(0, D - 1)),
               int'($urandom_range(0, W - 1)), 14'($urandom_range(0, 3)));
      idle(4);
      chk("drain", 32'(q.size()), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/tag_ram_sync_nway.md
# tag_ram_sync_nway

Parametrised N-way tag memory with synchronous read, per-entry valid bits, hardware clear sweep and a registered hit compare. It replaces the single-way, file-initialised tag RAM in the state-wise cache path: the controller issues lookup, fill and invalidate requests over a valid/ready handshake and gets hit/way results one cycle later. Contents are defined by a hardware sweep after reset, not by a memory-init file.

## Interface
- AWIDTH, 3: index width; DEPTH = 1 << AWIDTH entries per way.
- TWIDTH, 14: tag width.
- WAYS, 2: way count, 1..8. WWIDTH = max(1, clog2(WAYS)).
- clock  in  1  rising-edge clock, single clock domain.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- req_op  in  2  00 lookup, 01 fill, 10 invalidate way, 11 invalidate index (all ways).
- req_addr  in  AWIDTH  index.
- req_way  in  WWIDTH  target way for fill or invalidate way; ignored otherwise.
- req_tag  in  TWIDTH  fill data or lookup compare tag.
- rsp_valid  out  1  lookup result valid, one-cycle pulse per lookup.
- rsp_hit  out  1  some valid way matched req_tag.
- rsp_way  out  WWIDTH  lowest-numbered matching way; 0 on miss.
- rsp_tags  out  WAYS*TWIDTH  stored tags of the looked-up index, way 0 in the LSBs.
- rsp_vbits  out  WAYS  stored valid bits of the looked-up index.
- init_start  in  1  software clear request, acted on only in READY.
- init_busy  out  1  clear sweep in progress.

## Operation
- Each way stores {valid, tag[TWIDTH-1:0]} per index.
- FSM states:
  - INIT: sweeps index 0..DEPTH-1, writing {0, 0} to every way, one index per cycle. After writing index DEPTH-1, it moves to READY.
  - READY: accepts requests; a request is accepted on req_valid && req_ready.
- Reset places the FSM in INIT with sweep index 0. On release, the sweep runs for DEPTH cycles.
- A reset asserted mid-sweep or mid-operation aborts it, and the sweep restarts from 0 on release.
- req_ready = (state == READY). It is combinational from state only and never depends on req_valid.
- Request ops:
  - Lookup: registers the read index and req_tag. The next cycle drives rsp_valid = 1 with compare results.
  - Fill: writes {1, req_tag} to req_way at req_addr. No response.
  - Invalidate way: writes valid = 0 to req_way. The tag is left unchanged. No response.
  - Invalidate index: clears valid in all ways at req_addr. No response.
- Hit = OR over ways of (valid && tag == compare tag). rsp_way comes from a lowest-index priority encoder. Duplicate matching tags are legal, and way priority resolves them.
- init_start in READY moves the FSM to INIT on the next edge.
  - A request accepted in that same cycle still completes, and its lookup response still appears.
  - init_start while in INIT is ignored.
- Out-of-range req_way (>= WAYS) on a write: no way is written.

## Timing
- Reset values: req_ready 0, init_busy 1, rsp_valid 0, rsp_hit 0, rsp_way 0, rsp_tags 0, rsp_vbits 0.
- Sweep length: init_busy is high for exactly DEPTH cycles after reset release (or after the init_start edge). req_ready rises in the cycle init_busy falls.
- Lookup latency: request accepted at edge n; rsp_* valid in cycle n+1 (after edge n+1 has been sampled) and held until the next lookup response. rsp_valid is high for one cycle only.
- Writes take effect at the accepting edge. A lookup to the same index on the next cycle sees the new contents, so back-to-back fill then lookup hits.
- Throughput: one request per cycle in READY, with no bubbles.

## Structure
- Shared package tag_ram_pkg:
  - op encodings OP_LOOKUP, OP_FILL, OP_INV_WAY, OP_INV_IDX;
  - FSM state type {INIT, READY};
  - WWIDTH helper function.
- Sub-module ram_sync_rw_way: one way's storage, DEPTH x (TWIDTH+1), with write enable, write data, address and registered read address. It is instantiated WAYS times through generate.
- The top level holds the FSM, sweep counter, write-enable decode, compare and priority encoder, and response registers.

## Test plan
- Reset release with defaults: init_busy high for 8 cycles, req_ready low throughout, then req_ready = 1. A lookup of every index returns rsp_hit = 0 and rsp_vbits = 2'b00.
- Fill way 1, index 5, tag 14'h1A3; next-cycle lookup of index 5, tag 14'h1A3 -> rsp_hit = 1, rsp_way = 1, rsp_vbits = 2'b10. Lookup with tag 14'h1A4 -> miss.
- Fill tag 14'h0F0 into both ways at index 2, then lookup -> rsp_way = 0. Invalidate way 0, then lookup -> rsp_way = 1. Invalidate index 2, then lookup -> miss with rsp_tags still showing 14'h0F0.
- Fills in several indices, then init_start together with a lookup of a filled index -> the lookup still hits. Then 8 busy cycles follow, and afterwards all lookups miss.
- Reset asserted at sweep index 4 and released -> a full 8-cycle sweep restarts. All outputs are at reset values while reset_n is low.
- Back-to-back stream of 16 random ops with req_valid held high, checked against a reference model: one rsp_valid per lookup, each exactly one cycle later.
